// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_stage
// Description : EX/MEM pipeline register placed after the ALU. It captures
//               the ALU result, destination register and write enable. It
//               resolves beq/bne and emits a one-cycle PC redirect pulse. It
//               hands beats to MEM/WB over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Configuration macro:
//   EXMEM_SKID_EN  - when defined, a second (skid) entry is added. in_ready
//                    then comes from registered state only. When undefined,
//                    the stage is a single register with a combinational
//                    in_ready.
// ----------------------------------------------------------------------------
// Ports:
//   clk, rstn                  clock / asynchronous active-low reset
//   in_valid / in_ready        EX-side handshake
//   in_alu_c, in_zero          ALU result and Zero flag
//   in_br                      00 none, 01 beq, 10 bne, 11 reserved (none)
//   in_pc, in_imm              branch base PC and sign-extended offset
//   in_rd, in_regwrite         destination register and write enable
//   flush                      synchronous kill of all buffered beats
//   out_valid / out_ready      MEM-side handshake
//   out_alu_c, out_rd,
//   out_regwrite               registered beat presented to MEM
//   redirect_valid/_pc         one-cycle taken-branch redirect
// ============================================================================
module ex_mem_stage #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_alu_c,
  input  logic            in_zero,
  input  logic [1:0]      in_br,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [RD_W-1:0] in_rd,
  input  logic            in_regwrite,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_alu_c,
  output logic [RD_W-1:0] out_rd,
  output logic            out_regwrite,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [1:0] C_BR_BEQ = 2'b01;
  localparam logic [1:0] C_BR_BNE = 2'b10;
  // Beat payload layout: {alu_c, rd, regwrite}
  localparam int         C_BEAT_W = XLEN + RD_W + 1;

  // --------------------------------------------------------------------------
  // Input decode
  // --------------------------------------------------------------------------
  logic                w_accept;
  logic                w_drain;
  logic                w_is_branch;
  logic                w_taken;
  logic [XLEN-1:0]     w_target;
  logic                w_regwrite;
  logic [C_BEAT_W-1:0] w_beat;

  assign w_accept    = in_valid & in_ready;
  assign w_drain     = out_valid & out_ready;
  assign w_is_branch = (in_br == C_BR_BEQ) | (in_br == C_BR_BNE);
  assign w_taken     = ((in_br == C_BR_BEQ) &  in_zero) |
                       ((in_br == C_BR_BNE) & ~in_zero);
  // The sum is truncated to XLEN, so the target wraps modulo 2^XLEN.
  assign w_target    = in_pc + in_imm;
  // Branches never write rd, and writes to x0 are dropped here so that MEM/WB
  // need not special-case them.
  assign w_regwrite  = in_regwrite & ~w_is_branch & (in_rd != '0);
  assign w_beat      = {in_alu_c, in_rd, w_regwrite};

  // --------------------------------------------------------------------------
  // Redirect: pulses for exactly the cycle after a taken branch is accepted.
  // The target register keeps its last value otherwise.
  // --------------------------------------------------------------------------
  logic            redir_valid_q, redir_valid_d;
  logic [XLEN-1:0] redir_pc_q,    redir_pc_d;

  always_comb begin
    redir_valid_d = w_accept & w_taken;
    redir_pc_d    = redir_pc_q;
    if (w_accept & w_taken) begin
      redir_pc_d = w_target;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
    end else begin
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
    end
  end

  assign redirect_valid = redir_valid_q;
  assign redirect_pc    = redir_pc_q;

  // --------------------------------------------------------------------------
  // Main register M (always present)
  // --------------------------------------------------------------------------
  logic                m_valid_q, m_valid_d;
  logic [C_BEAT_W-1:0] m_beat_q,  m_beat_d;

`ifdef EXMEM_SKID_EN
  // --------------------------------------------------------------------------
  // Two-entry buffer. in_ready comes only from the registered S valid bit, so
  // there is no combinational path from out_ready. An accepted beat can only
  // land in S while S is empty, so at most one beat is ever in flight toward
  // S. That keeps the ordering M-before-S trivially intact.
  // --------------------------------------------------------------------------
  logic                s_valid_q, s_valid_d;
  logic [C_BEAT_W-1:0] s_beat_q,  s_beat_d;

  assign in_ready = rstn & ~flush & ~s_valid_q;

  always_comb begin
    m_valid_d = m_valid_q;
    m_beat_d  = m_beat_q;
    s_valid_d = s_valid_q;
    s_beat_d  = s_beat_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else begin
      if (w_drain) begin
        if (s_valid_q) begin
          m_beat_d  = s_beat_q;
          s_valid_d = 1'b0;
        end else begin
          m_valid_d = 1'b0;
        end
      end
      // An accept implies S was empty, so the drain above only cleared M.
      if (w_accept) begin
        if (!m_valid_q || w_drain) begin
          m_valid_d = 1'b1;
          m_beat_d  = w_beat;
        end else begin
          s_valid_d = 1'b1;
          s_beat_d  = w_beat;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_valid_q <= 1'b0;
      s_beat_q  <= '0;
    end else begin
      s_valid_q <= s_valid_d;
      s_beat_q  <= s_beat_d;
    end
  end
`else
  // --------------------------------------------------------------------------
  // Single register. M can take a new beat whenever it is empty or draining
  // this cycle.
  // --------------------------------------------------------------------------
  assign in_ready = rstn & ~flush & (~m_valid_q | out_ready);

  always_comb begin
    m_valid_d = m_valid_q;
    m_beat_d  = m_beat_q;
    if (flush) begin
      m_valid_d = 1'b0;
    end else if (w_accept) begin
      m_valid_d = 1'b1;
      m_beat_d  = w_beat;
    end else if (w_drain) begin
      m_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid_q <= 1'b0;
      m_beat_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_beat_q  <= m_beat_d;
    end
  end

  assign out_valid    = m_valid_q;
  assign out_alu_c    = m_beat_q[C_BEAT_W-1 -: XLEN];
  assign out_rd       = m_beat_q[RD_W:1];
  assign out_regwrite = m_beat_q[0];

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_mem_stage
// Description : Self-checking bench for ex_mem_stage. A table of directed
//               vectors covers the streaming cases. Hand-written sequences
//               cover reset, backpressure, flush and mid-operation reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_stage;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_alu_c;
  logic        in_zero;
  logic [1:0]  in_br;
  logic [31:0] in_pc;
  logic [31:0] in_imm;
  logic [4:0]  in_rd;
  logic        in_regwrite;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_alu_c;
  logic [4:0]  out_rd;
  logic        out_regwrite;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_checks;
  int n_fail;

  ex_mem_stage #(.XLEN(32), .RD_W(5)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_alu_c       (in_alu_c),
    .in_zero        (in_zero),
    .in_br          (in_br),
    .in_pc          (in_pc),
    .in_imm         (in_imm),
    .in_rd          (in_rd),
    .in_regwrite    (in_regwrite),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_alu_c      (out_alu_c),
    .out_rd         (out_rd),
    .out_regwrite   (out_regwrite),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [31:0] c;
    logic        z;
    logic [1:0]  br;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rw;
    logic        e_valid;
    logic [31:0] e_c;
    logic [4:0]  e_rd;
    logic        e_rw;
    logic        e_rv;
    logic [31:0] e_rpc;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [31:0] c, input logic z,
                       input logic [1:0] br, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [4:0] rd, input logic rw);
    in_valid    = vld;
    in_alu_c    = c;
    in_zero     = z;
    in_br       = br;
    in_pc       = pc;
    in_imm      = imm;
    in_rd       = rd;
    in_regwrite = rw;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //        vld c            z     br     pc            imm           rd rw  ev  e_c          erd erw erv e_rpc
    vecs[0]  = '{1, 32'h5,        0, 2'b00, 32'h0,        32'h0,        3, 1,  1, 32'h5,        3, 1,  0, 32'h0};
    vecs[1]  = '{1, 32'h6,        0, 2'b00, 32'h0,        32'h0,        3, 1,  1, 32'h6,        3, 1,  0, 32'h0};
    vecs[2]  = '{1, 32'h7,        0, 2'b00, 32'h0,        32'h0,        3, 1,  1, 32'h7,        3, 1,  0, 32'h0};
    // beq taken with negative offset
    vecs[3]  = '{1, 32'h0,        1, 2'b01, 32'h100,      32'hFFFFFFF0, 3, 1,  1, 32'h0,        3, 0,  1, 32'h0F0};
    // bubble: output drains, redirect_pc holds
    vecs[4]  = '{0, 32'h0,        0, 2'b00, 32'h0,        32'h0,        0, 0,  0, 32'h0,        0, 0,  0, 32'h0F0};
    // bne not taken: beat forwarded, no write
    vecs[5]  = '{1, 32'h9,        1, 2'b10, 32'h200,      32'h40,       4, 1,  1, 32'h9,        4, 0,  0, 32'h0F0};
    // bne taken
    vecs[6]  = '{1, 32'hA,        0, 2'b10, 32'h200,      32'h40,       4, 1,  1, 32'hA,        4, 0,  1, 32'h240};
    // beq not taken
    vecs[7]  = '{1, 32'hB,        0, 2'b01, 32'h300,      32'h8,        4, 1,  1, 32'hB,        4, 0,  0, 32'h240};
    // reserved branch kind behaves as plain ALU op
    vecs[8]  = '{1, 32'h11,       1, 2'b11, 32'h400,      32'h8,        5, 1,  1, 32'h11,       5, 1,  0, 32'h240};
    // target wraps around 2^32
    vecs[9]  = '{1, 32'h0,        1, 2'b01, 32'hFFFFFFFC, 32'h8,        6, 0,  1, 32'h0,        6, 0,  1, 32'h4};
    // write to x0 is suppressed
    vecs[10] = '{1, 32'h22,       0, 2'b00, 32'h0,        32'h0,        0, 1,  1, 32'h22,       0, 0,  0, 32'h4};
    // two taken branches back to back: two pulses
    vecs[11] = '{1, 32'h0,        1, 2'b01, 32'h10,       32'h10,       1, 0,  1, 32'h0,        1, 0,  1, 32'h20};
    vecs[12] = '{1, 32'h1,        0, 2'b10, 32'h30,       32'h4,        1, 0,  1, 32'h1,        1, 0,  1, 32'h34};
    vecs[13] = '{1, 32'hDEAD,     0, 2'b00, 32'h0,        32'h0,        7, 0,  1, 32'hDEAD,     7, 0,  0, 32'h34};

    // ---------------- reset ----------------
    rstn      = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1, 32'h1234, 0, 2'b01, 32'h100, 32'h4, 3, 1);
    step();
    step();
    chk("reset in_ready", {31'b0, in_ready}, 32'h0);
    chk("reset out_valid", {31'b0, out_valid}, 32'h0);
    chk("reset out_alu_c", out_alu_c, 32'h0);
    chk("reset out_rd", {27'b0, out_rd}, 32'h0);
    chk("reset out_regwrite", {31'b0, out_regwrite}, 32'h0);
    chk("reset redirect_valid", {31'b0, redirect_valid}, 32'h0);
    chk("reset redirect_pc", redirect_pc, 32'h0);
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
    #2 rstn = 1'b1;
    #1;
    chk("post-reset in_ready", {31'b0, in_ready}, 32'h1);
    step();

    // ---------------- table-driven vectors (out_ready=1) ----------------
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].vld, vecs[i].c, vecs[i].z, vecs[i].br, vecs[i].pc,
            vecs[i].imm, vecs[i].rd, vecs[i].rw);
      chk($sformatf("v%0d in_ready", i), {31'b0, in_ready}, 32'h1);
      step();
      chk($sformatf("v%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_valid});
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d out_alu_c", i), out_alu_c, vecs[i].e_c);
        chk($sformatf("v%0d out_rd", i), {27'b0, out_rd}, {27'b0, vecs[i].e_rd});
        chk($sformatf("v%0d out_regwrite", i), {31'b0, out_regwrite}, {31'b0, vecs[i].e_rw});
      end
      chk($sformatf("v%0d redirect_valid", i), {31'b0, redirect_valid}, {31'b0, vecs[i].e_rv});
      chk($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].e_rpc);
    end
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
    step();
    chk("drain out_valid", {31'b0, out_valid}, 32'h0);
    chk("pulse ends", {31'b0, redirect_valid}, 32'h0);

    // ---------------- backpressure ----------------
    out_ready = 1'b0;
`ifdef EXMEM_SKID_EN
    drive(1, 32'hA, 0, 2'b00, 0, 0, 2, 1);
    step();
    chk("bp A out", out_alu_c, 32'hA);
    chk("bp in_ready after A", {31'b0, in_ready}, 32'h1);
    drive(1, 32'hB, 0, 2'b00, 0, 0, 2, 1);
    step();
    chk("bp hold A", out_alu_c, 32'hA);
    chk("bp in_ready S full", {31'b0, in_ready}, 32'h0);
    drive(1, 32'hC, 0, 2'b00, 0, 0, 2, 1);
    step();
    chk("bp still A", out_alu_c, 32'hA);
    chk("bp out_valid held", {31'b0, out_valid}, 32'h1);
    out_ready = 1'b1;
    #1;
    chk("bp in_ready no comb path", {31'b0, in_ready}, 32'h0);
    step();
    chk("bp B out", out_alu_c, 32'hB);
    chk("bp in_ready reopened", {31'b0, in_ready}, 32'h1);
    step();
    chk("bp C out", out_alu_c, 32'hC);
    chk("bp C valid", {31'b0, out_valid}, 32'h1);
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
    step();
    chk("bp no duplicate", {31'b0, out_valid}, 32'h0);
`else
    drive(1, 32'hA, 0, 2'b00, 0, 0, 2, 1);
    #1;
    chk("bp in_ready empty", {31'b0, in_ready}, 32'h1);
    step();
    chk("bp A out", out_alu_c, 32'hA);
    drive(1, 32'hB, 0, 2'b00, 0, 0, 2, 1);
    #1;
    chk("bp in_ready full", {31'b0, in_ready}, 32'h0);
    step();
    chk("bp hold A", out_alu_c, 32'hA);
    chk("bp out_valid held", {31'b0, out_valid}, 32'h1);
    out_ready = 1'b1;
    #1;
    chk("bp in_ready draining", {31'b0, in_ready}, 32'h1);
    step();
    chk("bp B out", out_alu_c, 32'hB);
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
    step();
    chk("bp no duplicate", {31'b0, out_valid}, 32'h0);
`endif

    // ---------------- flush with full buffer and pending redirect ----------------
    out_ready = 1'b0;
    drive(1, 32'h77, 1, 2'b01, 32'h1000, 32'h20, 8, 0);
    step();
    chk("fl pre out_valid", {31'b0, out_valid}, 32'h1);
    chk("fl pre redirect", {31'b0, redirect_valid}, 32'h1);
    chk("fl pre redirect_pc", redirect_pc, 32'h1020);
    drive(1, 32'h78, 0, 2'b00, 0, 0, 8, 1);
    step();
    chk("fl redirect cleared", {31'b0, redirect_valid}, 32'h0);
    flush = 1'b1;
    drive(1, 32'h55, 1, 2'b01, 32'h2000, 32'h4, 9, 1);
    #1;
    chk("fl in_ready", {31'b0, in_ready}, 32'h0);
    step();
    chk("fl out_valid", {31'b0, out_valid}, 32'h0);
    chk("fl redirect_valid", {31'b0, redirect_valid}, 32'h0);
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
    step();
    chk("fl beat not accepted", {31'b0, out_valid}, 32'h0);
    chk("fl no late redirect", {31'b0, redirect_valid}, 32'h0);

    // ---------------- reset mid-operation ----------------
    out_ready = 1'b0;
    drive(1, 32'h99, 1, 2'b01, 32'h40, 32'h4, 3, 1);
    step();
    chk("mr pre out_valid", {31'b0, out_valid}, 32'h1);
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
    #2 rstn = 1'b0;
    #1;
    chk("mr out_valid", {31'b0, out_valid}, 32'h0);
    chk("mr out_alu_c", out_alu_c, 32'h0);
    chk("mr redirect_valid", {31'b0, redirect_valid}, 32'h0);
    chk("mr redirect_pc", redirect_pc, 32'h0);
    chk("mr in_ready", {31'b0, in_ready}, 32'h0);
    step();
    rstn = 1'b1;
    step();
    chk("mr recovered out_valid", {31'b0, out_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
